// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub
//  Description : Bit-serial subtractor computing (a - b - bin) mod 2^WIDTH
//                LSB first over WIDTH cycles, one full-subtractor cell plus a
//                registered borrow. Parallel load, parallel result, one-cycle
//                done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // Bit-count width, derived from WIDTH.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CW-1:0]    r_count;

    logic             w_d;
    logic             w_bout;

    // Single-bit full-subtractor cell fed by the operand LSBs and running borrow.
    always_comb begin
        w_d    = r_sa[0] ^ r_sb[0] ^ r_borrow;
        w_bout = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_borrow);
    end

    // Control FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
        end else begin
            // done is a pulse: only the DONE state raises it for one cycle.
            done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_borrow <= bin;
                        r_res    <= '0;
                        r_count  <= '0;
                        busy     <= 1'b1;
                        r_state  <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    // Result bits enter at the MSB so after WIDTH shifts
                    // the first (LSB) result bit lands at bit 0.
                    r_res    <= {w_d, r_res[WIDTH-1:1]};
                    r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
                    r_borrow <= w_bout;
                    r_count  <= r_count + 1'b1;
                    if (r_count == c_last_bit) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    diff    <= r_res;
                    bout    <= r_borrow;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_sub
//  Description : Self-checking bench for serial_sub at WIDTH=8 (directed and
//                random operations) and WIDTH=3 (all operand combinations),
//                compared against an integer-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       bin3 = 1'b0;
    logic       busy3, done3, bout3;
    logic [2:0] diff3;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] prev_diff8 = '0;

    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_sub #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .diff(diff3), .bout(bout3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer subtraction; borrow means the result went negative.
    function automatic int ref_diff(input int av, input int bv, input int bi, input int w);
        int r;
        r = av - bv - bi;
        return r & ((1 << w) - 1);
    endfunction

    function automatic int ref_bout(input int av, input int bv, input int bi);
        return (av - bv - bi < 0) ? 1 : 0;
    endfunction

    // One WIDTH=8 operation. Called idle, #1 after a rising edge.
    // poke: cycle index at which a conflicting start (0xAA-0x55) is pulsed.
    // noise: random start pulses and operand churn while busy.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                           input int poke, input bit noise);
        int cyc;
        int busy_cnt;
        int ed;
        int eb;
        ed = ref_diff(int'(av), int'(bv), int'(bi), 8);
        eb = ref_bout(int'(av), int'(bv), int'(bi));
        start8 = 1'b1; a8 = av; b8 = bv; bin8 = bi;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        check("diff_hold", int'(diff8), int'(prev_diff8));
        cyc = 0;
        busy_cnt = 0;
        while (!done8 && cyc < 40) begin
            if (busy8) busy_cnt++;
            if (cyc == poke) begin
                start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
            end else begin
                start8 = noise ? 1'($urandom) : 1'b0;
                if (noise) begin a8 = 8'($urandom); b8 = 8'($urandom); end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start8 = 1'b0;
        check("latency", cyc, 9);
        check("busy_cycles", busy_cnt, 9);
        check("diff", int'(diff8), ed);
        check("bout", int'(bout8), eb);
        check("busy_at_done", int'(busy8), 0);
        prev_diff8 = 8'(ed);
        @(posedge clk); #1;
        check("done_pulse", int'(done8), 0);
        check("idle_after", int'(busy8), 0);
    endtask

    initial begin
        int seen;
        int cyc;
        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", int'(busy8), 0);
        check("rst_done", int'(done8), 0);
        check("rst_diff", int'(diff8), 0);
        check("rst_bout", int'(bout8), 0);

        // Directed vectors
        run_op8(8'h05, 8'h03, 1'b0, -1, 1'b0);
        run_op8(8'h03, 8'h05, 1'b0, -1, 1'b0);
        run_op8(8'h00, 8'hFF, 1'b1, -1, 1'b0);
        run_op8(8'h80, 8'h00, 1'b1, -1, 1'b0);
        run_op8(8'hFF, 8'hFF, 1'b0, -1, 1'b0);

        // Start while busy is ignored
        run_op8(8'h10, 8'h01, 1'b0, 3, 1'b0);

        // Reset in the middle of SHIFT aborts the operation
        start8 = 1'b1; a8 = 8'h40; b8 = 8'h20; bin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", int'(busy8), 0);
        check("abort_done", int'(done8), 0);
        check("abort_diff", int'(diff8), 0);
        check("abort_bout", int'(bout8), 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) seen++;
            @(posedge clk); #1;
        end
        check("abort_no_done", seen, 0);
        prev_diff8 = '0;
        run_op8(8'h40, 8'h20, 1'b0, -1, 1'b0);

        // Reset and start together: reset wins
        rst = 1'b1; start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        @(posedge clk); #1;
        rst = 1'b0; start8 = 1'b0;
        check("rst_start_busy", int'(busy8), 0);
        @(posedge clk); #1;
        check("rst_start_busy2", int'(busy8), 0);
        prev_diff8 = '0;

        // Randomized operations with start noise while busy
        for (int i = 0; i < 40; i++) begin
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), -1, 1'(i % 2));
        end

        // WIDTH=3 exhaustive, back-to-back starts
        for (int i = 0; i < 128; i++) begin
            int av;
            int bv;
            int bi;
            av = (i >> 4) & 7;
            bv = (i >> 1) & 7;
            bi = i & 1;
            start3 = 1'b1; a3 = 3'(av); b3 = 3'(bv); bin3 = 1'(bi);
            @(posedge clk); #1;
            start3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom); bin3 = 1'($urandom);
            cyc = 0;
            while (!done3 && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("w3_latency", cyc, 4);
            check("w3_diff", int'(diff3), ref_diff(av, bv, bi, 3));
            check("w3_bout", int'(bout3), ref_bout(av, bv, bi));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial multi-bit subtractor that computes a - b - bin over WIDTH clock cycles.
- Built around the single-bit full-subtractor cell (d = a^b^bin, bout = (~a&b) | (~(a^b)&bin)) plus a registered borrow.
- Operands are loaded in parallel, processed LSB first, and the result is presented in parallel with a one-cycle done pulse.
- Sits downstream of the combinational full-subtractor cell as the first sequential arithmetic stage in the practice datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- CW, $clog2(WIDTH+1), bit-count register width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- bin  input  1  initial borrow-in; captured on accepted start
- busy  output  1  high while an operation is in progress (states SHIFT and DONE)
- done  output  1  one-cycle pulse when diff/bout become valid
- diff  output  WIDTH  registered result (a - b - bin) mod 2^WIDTH
- bout  output  1  registered final borrow-out (1 when a < b + bin, unsigned)

Behaviour:
- One clock, clk. rst is synchronous and active-high, with priority over everything else.
- Reset values: busy=0, done=0, diff=0, bout=0, FSM=IDLE. Internal shift registers, borrow register and count are cleared to 0.
- FSM states and transitions:
  - IDLE: start=1 loads shift regs sa<=a, sb<=b, borrow<=bin, res<=0, count<=0, then goes to SHIFT. start=0 stays in IDLE.
  - SHIFT: each cycle computes the bit from sa[0], sb[0], borrow:
    - res <= {d, res[WIDTH-1:1]}; sa and sb shift right by 1 (zero fill); borrow <= bit bout; count <= count+1.
    - When count reaches WIDTH-1 (the last bit is being processed), goes to DONE.
  - DONE: diff <= res, bout <= borrow, done=1 for exactly this cycle; goes to IDLE.
- Latency:
  - start accepted at edge N.
  - WIDTH SHIFT cycles occupy edges N+1..N+WIDTH.
  - diff/bout update and done is high in the cycle following edge N+WIDTH+1.
  - Throughput is one operation per WIDTH+2 cycles.
- start while busy=1 (SHIFT or DONE) is ignored. No queueing, and no effect on the in-flight operation.
- a, b and bin may change freely after the accepting edge. Only the captured values are used.
- diff/bout hold their last value until the next DONE. They are not cleared on a new start.
- done is registered and glitch-free, never asserted for two consecutive cycles.
- Reset during SHIFT aborts the operation: busy=0 on the next cycle, no done pulse, diff/bout=0.
- rst and start high together: reset wins, FSM stays in IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. Signed interpretation (two's complement) is the consumer's concern. bout is the unsigned borrow, not signed overflow.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, one start pulse -> exactly 9 cycles later done=1 for 1 cycle, diff=0x02, bout=0. busy high for 9 cycles (8 SHIFT + DONE).
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1. Then a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1.
- a=0x80, b=0x00, bin=1 -> diff=0x7F, bout=0. a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0.
- Start 0x10-0x01. Pulse start again 3 cycles later with a=0xAA, b=0x55 -> second start ignored, diff=0x0F, bout=0. a/b changed after acceptance have no effect.
- Start 0x40-0x20, assert rst for 1 cycle during SHIFT count=4 -> busy=0 next cycle, no done pulse, diff=0, bout=0. A following start of 0x40-0x20 completes with diff=0x20, bout=0.
- Exhaustive at WIDTH=3: all 128 (a, b, bin) combinations, back-to-back starts issued the cycle after each done -> diff and bout match the reference model (a-b-bin) mod 8 and borrow for every case.
